// File: rtl/jam_pkg.sv
// Shared definitions for the jam cost-table arbiter: default widths, FSM states,
// table row type and a modulo-increment helper for the round-robin pointer.
package jam_pkg;

   localparam int JAM_IDX_W  = 3;
   localparam int JAM_COST_W = 7;
   localparam int JAM_TBL_N  = 2**JAM_IDX_W;

   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      SERVE
   } state_t;

   typedef logic [JAM_COST_W-1:0] tbl_row_t [JAM_TBL_N];

   function automatic int wrap_inc(input int value, input int modulus);
      return (value + 1 >= modulus) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/jam_rr_arbiter.sv
// Round-robin grant selection for the cost-table lookups; with JAM_ARB_BURST_EN
// defined, a granted engine keeps priority for up to one full table row of grants.
module jam_rr_arbiter
   import jam_pkg::*;
#(
   parameter int NUM_REQ = 4,
`ifdef JAM_ARB_BURST_EN
   parameter int IDX_W   = JAM_IDX_W,
`endif
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
`ifdef JAM_ARB_BURST_EN
   input  logic [IDX_W:0]     burst_cnt,
   output logic [IDX_W:0]     burst_cnt_next,
`endif
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   gnt_idx,
   output logic [PTR_W-1:0]   ptr_next
);

`ifdef JAM_ARB_BURST_EN
   localparam int BURST_LEN = 2**IDX_W;
`endif

   logic grant_any;

   // Scan from the pointer upward, wrapping, and take the first live request.
   always_comb begin
      int idx;
      grant_any = 1'b0;
      gnt       = '0;
      gnt_idx   = ptr;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (enable && !grant_any && req[idx]) begin
            grant_any = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      ptr_next = ptr;
`ifdef JAM_ARB_BURST_EN
      burst_cnt_next = burst_cnt;
      if (grant_any) begin
         // The pointer parks on the bursting engine until the row is exhausted.
         if (gnt_idx == ptr && burst_cnt != '0) begin
            burst_cnt_next = burst_cnt + 1'b1;
         end else begin
            burst_cnt_next = (IDX_W+1)'(1);
         end
         if (burst_cnt_next == (IDX_W+1)'(BURST_LEN)) begin
            ptr_next       = PTR_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
            burst_cnt_next = '0;
         end else begin
            ptr_next = gnt_idx;
         end
      end
`else
      if (grant_any) begin
         ptr_next = PTR_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
      end
`endif
   end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Owns the worker/job cost table and shares it between search engines, one lookup
// per cycle with a one-cycle registered response. Optional burst mode: JAM_ARB_BURST_EN.
module jam_cost_arbiter
   import jam_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int COST_W  = JAM_COST_W,
   parameter int IDX_W   = JAM_IDX_W
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ld_valid,
   input  logic [IDX_W-1:0]         ld_w,
   input  logic [IDX_W-1:0]         ld_j,
   input  logic [COST_W-1:0]        ld_cost,
   input  logic                     ld_last,
   output logic                     tbl_ready,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_w,
   input  logic [NUM_REQ*IDX_W-1:0] req_j,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [COST_W-1:0]        rsp_cost
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int TBL_N = 2**IDX_W;

   state_t            state;
   state_t            state_next;
   logic [COST_W-1:0] tbl [TBL_N][TBL_N];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_ptr_next;
   logic [PTR_W-1:0]  gnt_idx;
   logic              arb_en;
   logic [IDX_W-1:0]  sel_w;
   logic [IDX_W-1:0]  sel_j;
`ifdef JAM_ARB_BURST_EN
   logic [IDX_W:0]    burst_cnt;
   logic [IDX_W:0]    burst_cnt_next;
`endif

   // Host writes always win, so a lookup can never race a write to the same entry.
   assign tbl_ready = (state == SERVE);
   assign arb_en    = tbl_ready && !ld_valid && !RST;
   assign sel_w     = req_w[gnt_idx*IDX_W +: IDX_W];
   assign sel_j     = req_j[gnt_idx*IDX_W +: IDX_W];

   jam_rr_arbiter #(
      .NUM_REQ        (NUM_REQ)
`ifdef JAM_ARB_BURST_EN
      ,.IDX_W         (IDX_W)
`endif
   ) u_arb (
      .enable         (arb_en),
      .req            (req),
      .ptr            (rr_ptr),
`ifdef JAM_ARB_BURST_EN
      .burst_cnt      (burst_cnt),
      .burst_cnt_next (burst_cnt_next),
`endif
      .gnt            (gnt),
      .gnt_idx        (gnt_idx),
      .ptr_next       (rr_ptr_next)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY, LOAD: begin
            if (ld_valid) begin
               state_next = ld_last ? SERVE : LOAD;
            end
         end
         SERVE: begin
            if (ld_valid && !ld_last) begin
               state_next = LOAD;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // Table contents are deliberately not reset; a load must precede any lookup.
   always_ff @(posedge CLK) begin
      if (ld_valid && !RST) begin
         tbl[ld_w][ld_j] <= ld_cost;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_valid <= '0;
         rsp_cost  <= '0;
         rr_ptr    <= '0;
`ifdef JAM_ARB_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         rsp_valid <= gnt;
         if (|gnt) begin
            rsp_cost <= tbl[sel_w][sel_j];
         end
         rr_ptr <= rr_ptr_next;
`ifdef JAM_ARB_BURST_EN
         // A load write breaks an active burst and hands priority to the next engine.
         if (ld_valid) begin
            burst_cnt <= '0;
            if (burst_cnt != '0) begin
               rr_ptr <= PTR_W'(wrap_inc(int'(rr_ptr), NUM_REQ));
            end
         end else begin
            burst_cnt <= burst_cnt_next;
         end
`endif
      end
   end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Self-checking bench for jam_cost_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural table/pointer model.
`timescale 1ns/1ps
module tb_jam_cost_arbiter;

   localparam int NR = 4;
   localparam int IW = 3;
   localparam int CW = 7;
   localparam int TN = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          ld_valid;
   logic [IW-1:0] ld_w;
   logic [IW-1:0] ld_j;
   logic [CW-1:0] ld_cost;
   logic          ld_last;
   logic          tbl_ready;
   logic [NR-1:0] req;
   logic [NR*IW-1:0] req_w;
   logic [NR*IW-1:0] req_j;
   logic [NR-1:0] gnt;
   logic [NR-1:0] rsp_valid;
   logic [CW-1:0] rsp_cost;

   int n_checks = 0;
   int n_fail   = 0;

   logic [CW-1:0] m_tbl [TN][TN];
   bit            m_ready;
   int            m_ptr;
   int            m_run;
   int            m_eng;
   logic [NR-1:0] m_rsp_valid;
   logic [CW-1:0] m_rsp_cost;

   jam_cost_arbiter #(
      .NUM_REQ   (NR),
      .COST_W    (CW),
      .IDX_W     (IW)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ld_valid  (ld_valid),
      .ld_w      (ld_w),
      .ld_j      (ld_j),
      .ld_cost   (ld_cost),
      .ld_last   (ld_last),
      .tbl_ready (tbl_ready),
      .req       (req),
      .req_w     (req_w),
      .req_j     (req_j),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_cost  (rsp_cost)
   );

   always #5 CLK = ~CLK;

   // Grant the model expects this cycle: first requester at or after the pointer.
   function automatic logic [NR-1:0] exp_gnt();
      logic [NR-1:0] g;
      bit hit;
      int k;
      g   = '0;
      hit = 1'b0;
      if (m_ready && !ld_valid && !RST) begin
         for (int i = 0; i < NR; i++) begin
            k = (m_ptr + i) % NR;
            if (!hit && req[k]) begin
               g[k] = 1'b1;
               hit  = 1'b1;
            end
         end
      end
      return g;
   endfunction

   // Advance the model with the current inputs, then step the clock.
   task automatic tick();
      logic [NR-1:0] g;
      int k;
      g = exp_gnt();
      k = -1;
      for (int i = 0; i < NR; i++) begin
         if (g[i]) k = i;
      end
      if (RST) begin
         m_ready     = 1'b0;
         m_ptr       = 0;
         m_run       = 0;
         m_eng       = 0;
         m_rsp_valid = '0;
         m_rsp_cost  = '0;
      end else begin
         m_rsp_valid = g;
         if (k >= 0) begin
            m_rsp_cost = m_tbl[req_w[k*IW +: IW]][req_j[k*IW +: IW]];
`ifdef JAM_ARB_BURST_EN
            if (k == m_eng && m_run > 0) begin
               m_run = m_run + 1;
            end else begin
               m_run = 1;
               m_eng = k;
            end
            if (m_run == TN) begin
               m_ptr = (k + 1) % NR;
               m_run = 0;
            end else begin
               m_ptr = k;
            end
`else
            m_ptr = (k + 1) % NR;
`endif
         end
         if (ld_valid) begin
            m_tbl[ld_w][ld_j] = ld_cost;
            m_ready = ld_last;
`ifdef JAM_ARB_BURST_EN
            if (m_run > 0) m_ptr = (m_eng + 1) % NR;
            m_run = 0;
`endif
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      req = 4'b1111;
      tick();
      RST = 1'b0;
      #3;
      n_checks++;
      if (tbl_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tbl_ready: got %b expected 0", tbl_ready); end
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
      n_checks++;
      if (rsp_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      n_checks++;
      if (rsp_cost !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_rsp_cost: got %0d expected 0", rsp_cost); end
      tick();
   endtask

   task automatic test_load();
      req = 4'b1111;
      for (int w = 0; w < TN; w++) begin
         for (int j = 0; j < TN; j++) begin
            ld_valid = 1'b1;
            ld_w     = 3'(w);
            ld_j     = 3'(j);
            ld_cost  = 7'(8 * w + j);
            ld_last  = (w == 7 && j == 7);
            #3;
            n_checks++;
            if (gnt !== 4'b0000 || tbl_ready !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL load_blocked (%0d,%0d): got gnt=%b ready=%b expected 0000/0", w, j, gnt, tbl_ready);
            end
            tick();
         end
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      req      = 4'b0000;
      #3;
      n_checks++;
      if (tbl_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL load_ready: got %b expected 1", tbl_ready); end
   endtask

   task automatic test_single_lookup();
      req   = 4'b0001;
      req_w = '0;
      req_j = '0;
      req_w[0 +: IW] = 3'd3;
      req_j[0 +: IW] = 3'd5;
      #3;
      n_checks++;
      if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
      tick();
      req = 4'b0000;
      #3;
      n_checks++;
      if (rsp_valid !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
      n_checks++;
      if (rsp_cost !== 7'd29) begin n_fail++; $display("[TB] FAIL single_rsp_cost: got %0d expected 29", rsp_cost); end
      tick();
      #3;
      n_checks++;
      if (rsp_valid !== 4'b0000 || rsp_cost !== 7'd29) begin
         n_fail++;
         $display("[TB] FAIL single_rsp_drop: got valid=%b cost=%0d expected 0000/29", rsp_valid, rsp_cost);
      end
   endtask

   task automatic test_round_robin();
      req = 4'b1111;
      for (int k = 0; k < NR; k++) begin
         req_w[k*IW +: IW] = 3'(k + 1);
         req_j[k*IW +: IW] = 3'(2 * k);
      end
      for (int c = 0; c < 6; c++) begin
         if (c == 5) req = 4'b0000;
         #3;
         n_checks++;
         if (gnt !== exp_gnt()) begin n_fail++; $display("[TB] FAIL rr_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt()); end
         n_checks++;
         if (rsp_valid !== m_rsp_valid || rsp_cost !== m_rsp_cost) begin
            n_fail++;
            $display("[TB] FAIL rr_rsp cycle %0d: got %b/%0d expected %b/%0d", c, rsp_valid, rsp_cost, m_rsp_valid, m_rsp_cost);
         end
         tick();
      end
   endtask

   task automatic test_load_during_serve();
      req = 4'b0010;
      req_w[1*IW +: IW] = 3'd2;
      req_j[1*IW +: IW] = 3'd2;
      ld_valid = 1'b1; ld_w = 3'd2; ld_j = 3'd2; ld_cost = 7'd99; ld_last = 1'b0;
      #3;
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL lds_gnt_blocked: got %b expected 0000", gnt); end
      tick();
      ld_valid = 1'b0;
      #3;
      n_checks++;
      if (tbl_ready !== 1'b0 || gnt !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL lds_not_ready: got ready=%b gnt=%b expected 0/0000", tbl_ready, gnt);
      end
      tick();
      ld_valid = 1'b1; ld_cost = 7'd7; ld_last = 1'b1;
      #3;
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL lds_last_gnt: got %b expected 0000", gnt); end
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      #3;
      n_checks++;
      if (tbl_ready !== 1'b1 || gnt !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL lds_resume: got ready=%b gnt=%b expected 1/0010", tbl_ready, gnt);
      end
      tick();
      req = 4'b0000;
      #3;
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_cost !== 7'd7) begin
         n_fail++;
         $display("[TB] FAIL lds_rsp: got %b/%0d expected 0010/7", rsp_valid, rsp_cost);
      end
      tick();
   endtask

   task automatic test_reset_mid_lookup();
      req = 4'b0100;
      req_w[2*IW +: IW] = 3'd6;
      req_j[2*IW +: IW] = 3'd1;
      #3;
      n_checks++;
      if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL rst_pre_gnt: got %b expected 0100", gnt); end
      tick();
      RST = 1'b1;
      #3;
      n_checks++;
      if (rsp_valid !== 4'b0100 || rsp_cost !== 7'd49 || gnt !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL rst_cycle: got rsp=%b/%0d gnt=%b expected 0100/49/0000", rsp_valid, rsp_cost, gnt);
      end
      tick();
      RST = 1'b0;
      #3;
      n_checks++;
      if (rsp_valid !== 4'b0000 || tbl_ready !== 1'b0 || gnt !== 4'b0000 || rsp_cost !== 7'd0) begin
         n_fail++;
         $display("[TB] FAIL rst_after: got rsp=%b/%0d ready=%b gnt=%b expected 0000/0/0/0000", rsp_valid, rsp_cost, tbl_ready, gnt);
      end
      tick();
      #3;
      n_checks++;
      if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL rst_req_ignored: got gnt=%b rsp=%b expected 0000/0000", gnt, rsp_valid);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 464; c++) begin
         req   = 4'($urandom_range(0, 15));
         req_w = 12'($urandom);
         req_j = 12'($urandom);
         if (c < 64) begin
            ld_valid = 1'b1;
            ld_w     = 3'(c / 8);
            ld_j     = 3'(c % 8);
            ld_last  = (c == 63);
            RST      = 1'b0;
         end else begin
            ld_valid = ($urandom_range(0, 9) == 0);
            ld_w     = 3'($urandom);
            ld_j     = 3'($urandom);
            ld_last  = ($urandom_range(0, 2) == 0);
            RST      = ($urandom_range(0, 99) == 0);
         end
         ld_cost = 7'($urandom);
         #3;
         n_checks++;
         if (gnt !== exp_gnt()) begin n_fail++; $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt()); end
         n_checks++;
         if (rsp_valid !== m_rsp_valid) begin n_fail++; $display("[TB] FAIL rand_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, m_rsp_valid); end
         n_checks++;
         if (rsp_cost !== m_rsp_cost) begin n_fail++; $display("[TB] FAIL rand_rsp_cost cycle %0d: got %0d expected %0d", c, rsp_cost, m_rsp_cost); end
         n_checks++;
         if (tbl_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, tbl_ready, m_ready); end
         tick();
      end
      RST      = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      req      = 4'b0000;
      tick();
   endtask

`ifdef JAM_ARB_BURST_EN
   task automatic test_burst();
      logic [NR-1:0] want;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      ld_valid = 1'b1; ld_w = 3'd0; ld_j = 3'd0; ld_cost = 7'd0; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      req = 4'b0011;
      for (int c = 0; c < 17; c++) begin
         req_w[0 +: IW] = 3'(c);
         req_w[IW +: IW] = 3'(c);
         if (c < 8) want = 4'b0001;
         else if (c < 16) want = 4'b0010;
         else want = 4'b0001;
         #3;
         n_checks++;
         if (gnt !== want) begin n_fail++; $display("[TB] FAIL burst_gnt cycle %0d: got %b expected %b", c, gnt, want); end
         tick();
      end
      req = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      RST = 1'b1; ld_valid = 1'b0; ld_w = '0; ld_j = '0; ld_cost = '0; ld_last = 1'b0;
      req = '0; req_w = '0; req_j = '0;
      m_ready = 1'b0; m_ptr = 0; m_run = 0; m_eng = 0; m_rsp_valid = '0; m_rsp_cost = '0;
      @(posedge CLK);
      #1;
      test_reset();
      test_load();
      test_single_lookup();
      test_round_robin();
      test_load_during_serve();
      test_reset_mid_lookup();
      test_random();
`ifdef JAM_ARB_BURST_EN
      test_burst();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
